// File: rtl/addsub_sched_if.sv
// Request, response and datapath bundle for the shared adder-subtractor sequencer.
interface addsub_sched_if #(
  parameter int WIDTH = 3,
  parameter int NREQ  = 2
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_op;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;

  logic                  dp_o;
  logic [WIDTH-1:0]      dp_a;
  logic [WIDTH-1:0]      dp_b;
  logic [WIDTH-1:0]      dp_s;
  logic                  dp_cout;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_cout;
  logic                  rsp_ovf;
  logic                  busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, dp_s, dp_cout, rsp_ready,
    output req_ready, dp_o, dp_a, dp_b, rsp_valid, rsp_id, rsp_result,
           rsp_cout, rsp_ovf, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, dp_s, dp_cout, rsp_ready,
    input  req_ready, dp_o, dp_a, dp_b, rsp_valid, rsp_id, rsp_result,
           rsp_cout, rsp_ovf, busy
  );
endinterface

// File: rtl/addsub_sched.sv
// Round-robin sequencer sharing one external adder-subtractor among NREQ requesters.
module addsub_sched #(
  parameter int WIDTH = 3,
  parameter int NREQ  = 2
) (
  input logic          clk,
  input logic          rst,
  addsub_sched_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   id_q;
  logic             op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             cout_q;
  logic             ovf_q;

  logic             gnt_vld;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;
  logic             ovf_d;

  // Search upward from ptr+1 with wrap; first valid requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(ptr_q) + k) % NREQ);
      if (!gnt_vld && bus.req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && !rst && gnt_vld) begin
      bus.req_ready[gnt_idx] = 1'b1;
    end
  end

  // Sign agreement of the operands must match add (same) or sub (different).
  assign ovf_d = ((a_q[WIDTH-1] ^ b_q[WIDTH-1]) == op_q) &&
                 (bus.dp_s[WIDTH-1] != a_q[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      id_q    <= '0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            op_q    <= bus.req_op[gnt_idx];
            a_q     <= bus.req_a[gnt_idx*WIDTH +: WIDTH];
            b_q     <= bus.req_b[gnt_idx*WIDTH +: WIDTH];
            id_q    <= gnt_idx;
            ptr_q   <= gnt_idx;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= bus.dp_s;
          cout_q  <= bus.dp_cout;
          ovf_q   <= ovf_d;
          state_q <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dp_o       = op_q;
  assign bus.dp_a       = a_q;
  assign bus.dp_b       = b_q;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_cout   = cout_q;
  assign bus.rsp_ovf    = ovf_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_addsub_sched.sv
// Self-checking bench for addsub_sched with a behavioural adder-subtractor datapath.
module tb_addsub_sched;
  localparam int W = 3;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;

  addsub_sched_if #(.WIDTH(W), .NREQ(N)) bus ();

  addsub_sched #(.WIDTH(W), .NREQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External datapath: a + (b ^ {W{o}}) + o
  always_comb begin
    {bus.dp_cout, bus.dp_s} = {1'b0, bus.dp_a} + {1'b0, (bus.dp_b ^ {W{bus.dp_o}})}
                              + {{W{1'b0}}, bus.dp_o};
  end

  typedef struct {
    int         id;
    logic [W-1:0] res;
    logic       cout;
    logic       ovf;
  } rsp_t;

  typedef struct {
    int         id;
    logic       op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic       cout;
    logic       ovf;
  } vec_t;

  rsp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    bus.req_op[id]        = op;
    bus.req_a[id*W +: W]  = a;
    bus.req_b[id*W +: W]  = b;
  endtask

  // Waits (bounded) for a grant; returns the granted index or -1.
  task automatic wait_grant(output int gid);
    gid = -1;
    for (int unsigned t = 0; t < 8; t++) begin
      #1;
      if (bus.req_ready != '0) begin
        gid = bus.req_ready[1] ? 1 : 0;
        break;
      end
      tick();
    end
    chk("grant_timeout", (gid >= 0), 1);
  endtask

  task automatic do_op(input vec_t v);
    int gid;
    bus.req_valid    = '0;
    bus.req_valid[v.id] = 1'b1;
    set_req(v.id, v.op, v.a, v.b);
    wait_grant(gid);
    if (gid < 0) return;
    chk("req_ready_onehot", bus.req_ready, 32'(1) << v.id);
    sb.push_back('{v.id, v.res, v.cout, v.ovf});
    tick();
    bus.req_valid = '0;
    chk("exec_dp_o", bus.dp_o, v.op);
    chk("exec_dp_a", bus.dp_a, v.a);
    chk("exec_dp_b", bus.dp_b, v.b);
    chk("exec_busy", bus.busy, 1);
    chk("exec_no_rsp", bus.rsp_valid, 0);
    tick();
    chk("rsp_valid_n1", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("idle_rsp_valid", bus.rsp_valid, 0);
    chk("idle_busy", bus.busy, 0);
  endtask

  // Response monitor: every transfer must match the oldest expectation.
  always @(negedge clk) begin : mon
    rsp_t e;
    #3;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(bus.rsp_id), e.id);
        chk("rsp_result", bus.rsp_result, e.res);
        chk("rsp_cout", bus.rsp_cout, e.cout);
        chk("rsp_ovf", bus.rsp_ovf, e.ovf);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   gid;
    int   grants;
    int   last;

    vecs[0] = '{0, 1'b1, 3'b011, 3'b010, 3'b001, 1'b1, 1'b0};
    vecs[1] = '{1, 1'b0, 3'b011, 3'b001, 3'b100, 1'b0, 1'b1};
    vecs[2] = '{0, 1'b1, 3'b100, 3'b001, 3'b011, 1'b1, 1'b1};
    vecs[3] = '{1, 1'b0, 3'b111, 3'b111, 3'b110, 1'b1, 1'b0};
    vecs[4] = '{0, 1'b1, 3'b000, 3'b001, 3'b111, 1'b0, 1'b0};
    vecs[5] = '{1, 1'b0, 3'b010, 3'b001, 3'b011, 1'b0, 1'b0};
    vecs[6] = '{1, 1'b1, 3'b010, 3'b110, 3'b100, 1'b0, 1'b1};

    rst           = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_cout", bus.rsp_cout, 0);
    chk("rst_rsp_ovf", bus.rsp_ovf, 0);
    chk("rst_dp_o", bus.dp_o, 0);
    chk("rst_dp_a", bus.dp_a, 0);
    chk("rst_dp_b", bus.dp_b, 0);
    chk("rst_busy", bus.busy, 0);
    rst           = 1'b0;
    bus.req_valid = '0;
    tick();

    for (int unsigned i = 0; i < 7; i++) begin
      do_op(vecs[i]);
    end

    // Both requesters continuously valid: grants alternate, 3 cycles apart.
    set_req(0, 1'b0, 3'b001, 3'b001);
    set_req(1, 1'b1, 3'b101, 3'b010);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    grants = 0;
    last   = 0;
    for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
      #1;
      chk("rr_ready_onehot", ($countones(bus.req_ready) <= 1), 1);
      if (bus.req_ready != '0) begin
        gid = bus.req_ready[1] ? 1 : 0;
        chk("rr_order", gid, grants % 2);
        if (grants > 0) chk("rr_spacing", cyc - last, 3);
        if (gid == 0) sb.push_back('{0, 3'b010, 1'b0, 1'b0});
        else          sb.push_back('{1, 3'b011, 1'b1, 1'b1});
        last = cyc;
        grants++;
      end
      tick();
      if (grants == 4) bus.req_valid = '0;
    end
    chk("rr_grants", grants, 4);
    for (int unsigned t = 0; t < 10 && sb.size() > 0; t++) tick();
    chk("rr_drained", sb.size(), 0);
    bus.rsp_ready = 1'b0;
    tick();

    // Response stalled five cycles while the other requester waits.
    bus.req_valid = 2'b01;
    set_req(0, 1'b1, 3'b011, 3'b010);
    wait_grant(gid);
    chk("stall_grant", gid, 0);
    sb.push_back('{0, 3'b001, 1'b1, 1'b0});
    tick();
    bus.req_valid = 2'b11;
    tick();
    for (int unsigned t = 0; t < 5; t++) begin
      chk("stall_rsp_valid", bus.rsp_valid, 1);
      chk("stall_rsp_result", bus.rsp_result, 3'b001);
      chk("stall_rsp_id", 32'(bus.rsp_id), 0);
      chk("stall_rsp_cout", bus.rsp_cout, 1);
      chk("stall_req_ready", bus.req_ready, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    tick();
    bus.rsp_ready = 1'b0;
    chk("stall_idle_busy", bus.busy, 0);
    chk("stall_idle_rsp_valid", bus.rsp_valid, 0);
    chk("stall_sb_empty", sb.size(), 0);

    // Reset during EXEC: op discarded, priority returns to requester 0.
    bus.req_valid = 2'b01;
    set_req(0, 1'b1, 3'b011, 3'b010);
    wait_grant(gid);
    tick();
    chk("rstx_in_exec", bus.busy, 1);
    rst           = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b0, 3'b001, 3'b010);
    set_req(1, 1'b0, 3'b111, 3'b001);
    #1;
    chk("rstx_req_ready", bus.req_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstx_rsp_valid", bus.rsp_valid, 0);
    chk("rstx_rsp_id", 32'(bus.rsp_id), 0);
    chk("rstx_rsp_result", bus.rsp_result, 0);
    chk("rstx_rsp_cout", bus.rsp_cout, 0);
    chk("rstx_rsp_ovf", bus.rsp_ovf, 0);
    chk("rstx_dp_o", bus.dp_o, 0);
    chk("rstx_dp_a", bus.dp_a, 0);
    chk("rstx_dp_b", bus.dp_b, 0);
    chk("rstx_busy", bus.busy, 0);
    chk("rstx_req0_wins", bus.req_ready, 2'b01);
    sb.push_back('{0, 3'b011, 1'b0, 1'b0});
    tick();
    bus.req_valid = '0;
    tick();
    chk("rstx_rsp_after", bus.rsp_valid, 1);
    tick();
    bus.rsp_ready = 1'b0;
    tick();

    chk("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/addsub_sched.md
# addsub_sched

Sequencer and round-robin arbiter that shares one combinational adder-subtractor datapath among NREQ requesters. The datapath is a selective-complement stage followed by an adder. The block accepts one operation at a time over a valid/ready handshake, drives the datapath operands and the complement-control bit, and captures the sum. It then presents the result, carry and signed overflow on a response channel. It sits between client logic and the adder-subtractor instance.

## Interface
- WIDTH, 3: operand and result width in bits.
- NREQ, 2: number of requesters, ≥2.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  bit i: requester i has an operation pending.
- req_ready  output  NREQ  bit i: requester i is accepted this cycle; one-hot or zero.
- req_op  input  NREQ  bit i: 0 = add (a+b), 1 = subtract (a−b).
- req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B; same packing as req_a.
- dp_o  output  1  complement control to the datapath.
- dp_a  output  WIDTH  datapath operand A.
- dp_b  output  WIDTH  datapath operand B.
- dp_s  input  WIDTH  datapath sum.
- dp_cout  input  1  datapath carry out.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  clog2(NREQ)  index of the requester being answered.
- rsp_result  output  WIDTH  captured sum.
- rsp_cout  output  1  captured carry.
- rsp_ovf  output  1  signed overflow of the operation.
- busy  output  1  high in EXEC or RESP.

## Operation
- Datapath contract: dp_s/dp_cout are combinational within one cycle and equal bits [WIDTH-1:0] and [WIDTH] of dp_a + (dp_b XOR {WIDTH{dp_o}}) + dp_o.
- FSM states:
  - IDLE: wait for a request.
  - EXEC: datapath operands are driven.
  - RESP: response is held.
- IDLE:
  - If any req_valid is set, grant g is the first set bit searching upward, with wrap, from ptr+1.
  - req_ready[g]=1 combinationally; all other bits are 0.
  - At the edge: latch op/a/b of g, latch id=g, set ptr=g, go to EXEC.
  - If no req_valid is set, stay in IDLE.
- EXEC:
  - dp_o/dp_a/dp_b come from registers, stable for the whole cycle.
  - At the edge: rsp_result←dp_s, rsp_cout←dp_cout, rsp_ovf←ovf, go to RESP.
- Overflow, using msb = bit WIDTH-1:
  - add: ovf = (a.msb==b.msb) & (dp_s.msb!=a.msb).
  - sub: ovf = (a.msb!=b.msb) & (dp_s.msb!=a.msb).
- RESP:
  - rsp_valid=1; rsp_id/result/cout/ovf are held constant.
  - Transfer when rsp_valid & rsp_ready, then go to IDLE.
  - If rsp_ready is low, stay in RESP indefinitely.
- req_ready is all-zero outside IDLE and in any cycle where rst=1.
- A requester that is not granted must hold its request; the block never drops a pending req_valid.
- Outputs dp_o/dp_a/dp_b hold their last values in IDLE and RESP. The datapath output is ignored outside EXEC.
- Reset in any state:
  - Next state is IDLE and ptr=NREQ-1, so requester 0 has first priority.
  - Any in-flight operation or response is discarded with no rsp_valid pulse.
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_cout=0, rsp_ovf=0, dp_o=0, dp_a=0, dp_b=0, busy=0, req_ready=0.

## Timing
- Request accepted at edge N (IDLE, valid&ready).
- EXEC occupies cycle N→N+1.
- rsp_valid=1 from edge N+1 onward.
- Earliest response transfer is at edge N+2; the earliest next acceptance is then at edge N+3 (IDLE cycle N+2→N+3).
- Minimum initiation interval: 3 cycles per operation.
- No combinational path from rsp_ready to req_ready; req_ready depends only on state, ptr and req_valid.
- Simultaneous requests: exactly one grant per IDLE cycle. With all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0.

## Test plan
- Single sub, requester 0, a=011, b=010, op=1 → dp_o=1 during EXEC; rsp_valid at N+1 with result=001, cout=1, ovf=0, id=0.
- Add overflow, requester 1, a=011, b=001, op=0 → result=100, cout=0, ovf=1, id=1.
- Sub overflow, a=100, b=001, op=1 → result=011, cout=1, ovf=1.
- Both requesters valid for 4 operations, rsp_ready tied high → grant order 0,1,0,1; each acceptance 3 cycles apart; req_ready never has two bits set.
- rsp_ready held low 5 cycles in RESP → rsp_* stable; req_ready=0 throughout; accept on rsp_ready=1, then IDLE.
- rst=1 for one cycle during EXEC → no rsp_valid for that operation; next cycle all outputs at reset values; requester 0 wins if both are valid.
